// File: rtl/data_mem_ws.sv
// Word-addressed data memory with WAIT_CYCLES wait states: ready_o pulses WAIT_CYCLES+1 edges after acceptance.
// Only one access is in flight at a time. mem_req_i is ignored during WAIT, so the master holds it until ready_o.
module data_mem_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int SIZE_BYTES  = 16384,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_req_i,
  input  logic                      write_enable_i,
  input  logic [DATA_WIDTH/8-1:0]   byte_enable_i,
  input  logic [31:0]               addr_i,
  input  logic [DATA_WIDTH-1:0]     write_data_i,
  output logic [DATA_WIDTH-1:0]     read_data_o,
  output logic                      ready_o,
  output logic                      err_o
);

  localparam int NB       = DATA_WIDTH / 8;
  localparam int OFF      = $clog2(NB);
  localparam int ABITS    = $clog2(SIZE_BYTES);
  localparam int AW       = ABITS - OFF;
  localparam int WORDS    = SIZE_BYTES / NB;
  localparam int CNT_INIT = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept, complete;

  logic [DATA_WIDTH-1:0] mem [WORDS];

  logic [AW-1:0]         lat_idx_q;
  logic                  lat_we_q;
  logic [NB-1:0]         lat_be_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic                  lat_oor_q;

  logic                  in_oor;
  logic [AW-1:0]         cur_idx;
  logic                  cur_we;
  logic [NB-1:0]         cur_be;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic                  cur_oor;

  assign in_oor = (addr_i >= 32'(SIZE_BYTES));

  // With zero wait states the access completes on its acceptance edge, so live inputs are used.
  always_comb begin
    if (state_q == ST_IDLE) begin
      cur_idx   = addr_i[ABITS-1:OFF];
      cur_we    = write_enable_i;
      cur_be    = byte_enable_i;
      cur_wdata = write_data_i;
      cur_oor   = in_oor;
    end else begin
      cur_idx   = lat_idx_q;
      cur_we    = lat_we_q;
      cur_be    = lat_be_q;
      cur_wdata = lat_wdata_q;
      cur_oor   = lat_oor_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            complete = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(CNT_INIT);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_idx_q   <= '0;
      lat_we_q    <= 1'b0;
      lat_be_q    <= '0;
      lat_wdata_q <= '0;
      lat_oor_q   <= 1'b0;
    end else if (accept) begin
      lat_idx_q   <= addr_i[ABITS-1:OFF];
      lat_we_q    <= write_enable_i;
      lat_be_q    <= byte_enable_i;
      lat_wdata_q <= write_data_i;
      lat_oor_q   <= in_oor;
    end
  end

  // RAM has no reset; rst_i gating keeps a zero-wait access from writing while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_i && complete && cur_we && !cur_oor) begin
      for (int i = 0; i < NB; i++) begin
        if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_o     <= 1'b0;
      err_o       <= 1'b0;
      read_data_o <= '0;
    end else begin
      ready_o <= complete;
      err_o   <= complete && cur_oor;
      if (complete && !cur_we) read_data_o <= cur_oor ? '0 : mem[cur_idx];
    end
  end

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench for data_mem_ws: three instances with 0, 2 and 3 wait states share the bus inputs.
module tb_data_mem_ws;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic [2:0]  rdy, err;
  logic [31:0] rd0, rd1, rd2;

  int errors = 0;
  int checks = 0;
  int lat_exp [3] = '{1, 3, 4};
  logic [31:0] last_rd [3];

  always #5 clk = ~clk;

  data_mem_ws #(.DATA_WIDTH(32), .SIZE_BYTES(16384), .WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[0]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .read_data_o(rd0), .ready_o(rdy[0]), .err_o(err[0]));
  data_mem_ws #(.DATA_WIDTH(32), .SIZE_BYTES(16384), .WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[1]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .read_data_o(rd1), .ready_o(rdy[1]), .err_o(err[1]));
  data_mem_ws #(.DATA_WIDTH(32), .SIZE_BYTES(16384), .WAIT_CYCLES(3)) u_w3 (
    .clk_i(clk), .rst_i(rst), .mem_req_i(req[2]), .write_enable_i(we), .byte_enable_i(be),
    .addr_i(addr), .write_data_i(wdata), .read_data_o(rd2), .ready_o(rdy[2]), .err_o(err[2]));

  typedef struct {
    int          sel;
    logic        w;
    logic [3:0]  b;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic logic [31:0] rd_of(input int s);
    case (s)
      0:       return rd0;
      1:       return rd1;
      default: return rd2;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic access(input int n, input vec_t v);
    int lat;
    @(negedge clk);
    we = v.w; be = v.b; addr = v.a; wdata = v.d; req[v.sel] = 1'b1;
    @(posedge clk);
    #1 req[v.sel] = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rdy[v.sel] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", n), 32'(lat), 32'(lat_exp[v.sel]));
    chk($sformatf("v%0d err", n), 32'(err[v.sel]), 32'(v.exp_err));
    if (!v.w) last_rd[v.sel] = v.exp_rd;
    chk($sformatf("v%0d rdata", n), rd_of(v.sel), last_rd[v.sel]);
    @(negedge clk);
    chk($sformatf("v%0d single pulse", n), 32'(rdy[v.sel]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    // sel: 0 -> 0 wait states, 1 -> 2 wait states, 2 -> 3 wait states
    vecs[0]  = '{1, 1'b1, 4'hF, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1, 1'b0, 4'hF, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1, 1'b1, 4'hF, 32'h20,   32'h11223344, 32'h0,        1'b0};
    vecs[3]  = '{1, 1'b1, 4'h5, 32'h20,   32'hAABBCCDD, 32'h0,        1'b0};
    vecs[4]  = '{1, 1'b0, 4'hF, 32'h20,   32'h0,        32'h11BB33DD, 1'b0};
    vecs[5]  = '{1, 1'b0, 4'h0, 32'h23,   32'h0,        32'h11BB33DD, 1'b0};
    vecs[6]  = '{1, 1'b1, 4'hF, 32'h0,    32'hCAFEF00D, 32'h0,        1'b0};
    vecs[7]  = '{1, 1'b1, 4'hF, 32'h4000, 32'h12345678, 32'h0,        1'b1};
    vecs[8]  = '{1, 1'b0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
    vecs[9]  = '{1, 1'b0, 4'hF, 32'h4000, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1, 1'b1, 4'h0, 32'h0,    32'h55555555, 32'h0,        1'b0};
    vecs[11] = '{1, 1'b0, 4'hF, 32'h0,    32'h0,        32'hCAFEF00D, 1'b0};
    vecs[12] = '{1, 1'b1, 4'hF, 32'h3FFC, 32'h0BADC0DE, 32'h0,        1'b0};
    vecs[13] = '{1, 1'b0, 4'hF, 32'h3FFC, 32'h0,        32'h0BADC0DE, 1'b0};
    vecs[14] = '{1, 1'b0, 4'hF, 32'hFFFFFFFC, 32'h0,    32'h0,        1'b1};
    vecs[15] = '{0, 1'b1, 4'hF, 32'h0,    32'h10203040, 32'h0,        1'b0};
    vecs[16] = '{0, 1'b1, 4'hF, 32'h4,    32'h50607080, 32'h0,        1'b0};
    vecs[17] = '{0, 1'b1, 4'hF, 32'h8,    32'h90A0B0C0, 32'h0,        1'b0};
    vecs[18] = '{0, 1'b1, 4'hF, 32'hC,    32'hD0E0F000, 32'h0,        1'b0};
    vecs[19] = '{0, 1'b0, 4'hF, 32'h4001, 32'h0,        32'h0,        1'b1};
    vecs[20] = '{0, 1'b1, 4'h8, 32'h4,    32'hEE000000, 32'h0,        1'b0};
    vecs[21] = '{2, 1'b1, 4'hF, 32'h30,   32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[22] = '{2, 1'b0, 4'hF, 32'h30,   32'h0,        32'hA5A5A5A5, 1'b0};

    rst = 1'b1; req = '0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset ready dut%0d", s), 32'(rdy[s]), 32'd0);
      chk($sformatf("reset err dut%0d", s), 32'(err[s]), 32'd0);
      chk($sformatf("reset rdata dut%0d", s), rd_of(s), 32'd0);
    end
    rst = 1'b0;

    for (int n = 0; n < NV; n++) access(n, vecs[n]);

    // Zero wait states, request held: one completion per cycle, data in order.
    @(negedge clk);
    we = 1'b0; be = 4'hF; addr = 32'h0; req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [31:0] exp_b;
      case (k)
        0:       exp_b = 32'h10203040;
        1:       exp_b = 32'hEE607080;
        2:       exp_b = 32'h90A0B0C0;
        default: exp_b = 32'hD0E0F000;
      endcase
      @(posedge clk);
      #1;
      if (k == 3) req[0] = 1'b0;
      else addr = 32'(k + 1) * 32'd4;
      @(negedge clk);
      chk($sformatf("burst%0d ready", k), 32'(rdy[0]), 32'd1);
      chk($sformatf("burst%0d rdata", k), rd0, exp_b);
    end
    @(negedge clk);
    chk("burst end ready", 32'(rdy[0]), 32'd0);
    last_rd[0] = 32'hD0E0F000;

    // Request toggled with another address during WAIT must not disturb the latched access.
    @(negedge clk);
    we = 1'b0; be = 4'hF; addr = 32'h10; req[1] = 1'b1;
    @(posedge clk);
    #1 req[1] = 1'b0; addr = 32'h20;
    @(negedge clk);
    req[1] = 1'b1;
    @(posedge clk);
    #1 req[1] = 1'b0;
    @(negedge clk);
    chk("wait ignore early ready", 32'(rdy[1]), 32'd0);
    @(negedge clk);
    chk("wait ignore ready", 32'(rdy[1]), 32'd1);
    chk("wait ignore rdata", rd1, 32'hDEADBEEF);
    @(negedge clk);
    chk("wait ignore no second pulse", 32'(rdy[1]), 32'd0);

    // Reset one cycle before the completion edge of a 3-wait-state write.
    @(negedge clk);
    we = 1'b1; be = 4'hF; addr = 32'h30; wdata = 32'h00000055; req[2] = 1'b1;
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset mid ready", 32'(rdy[2]), 32'd0);
    chk("reset mid err", 32'(err[2]), 32'd0);
    chk("reset mid rdata", rd2, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post reset idle%0d", k), 32'(rdy[2]), 32'd0);
    end
    for (int s = 0; s < 3; s++) last_rd[s] = '0;
    v = '{2, 1'b0, 4'hF, 32'h30, 32'h0, 32'hA5A5A5A5, 1'b0};
    access(100, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
